// File: rtl/quad_enc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : quad_enc_ctrl_if
//  Purpose  : Pin/register-side bundle of the quadrature encoder controller.
//  Revision : 1.0  initial release
// ============================================================================
interface quad_enc_ctrl_if #(
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 8
);
    logic [CH_NUM-1:0]       a_i;
    logic [CH_NUM-1:0]       b_i;
    logic [CH_NUM-1:0]       d_i;
    logic                    mode_i;
    logic                    clr_i;
    logic [CH_NUM*CNT_W-1:0] cw_cnt_o;
    logic [CH_NUM*CNT_W-1:0] ccw_cnt_o;
    logic [CH_NUM*CNT_W-1:0] pos_o;
    logic [CH_NUM-1:0]       dir_o;
    logic [CH_NUM-1:0]       evt_o;
    logic [CH_NUM-1:0]       err_o;
    logic [CH_NUM-1:0]       key_o;

    modport master (
        output a_i, b_i, d_i, mode_i, clr_i,
        input  cw_cnt_o, ccw_cnt_o, pos_o, dir_o, evt_o, err_o, key_o
    );

    modport slave (
        input  a_i, b_i, d_i, mode_i, clr_i,
        output cw_cnt_o, ccw_cnt_o, pos_o, dir_o, evt_o, err_o, key_o
    );
endinterface
`default_nettype wire

// File: rtl/quad_enc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : quad_enc_ctrl
//  Purpose  : Multi-channel quadrature encoder decoder with debounce, x1/x4
//             counting and saturating position. Macro ENC_KEY_EN adds the
//             push-key debounce and coarse-adjust position lock.
//  Revision : 1.0  initial release
// ============================================================================
module quad_enc_ctrl #(
    parameter int CH_NUM  = 2,
    parameter int CNT_W   = 8,
    parameter int CLK_DIV = 25000,
    parameter int DEB_LEN = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    quad_enc_ctrl_if.slave bus
);
`ifdef ENC_KEY_EN
    localparam int c_SIG_PER_CH = 3;
`else
    localparam int c_SIG_PER_CH = 2;
`endif
    localparam int                 c_NSIG     = CH_NUM * c_SIG_PER_CH;
    localparam int                 c_DIV_W    = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]         c_DEB_LAST = 4'(DEB_LEN - 1);
    localparam logic [CNT_W-1:0]   c_POS_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]   c_POS_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

    wire [c_NSIG-1:0]       w_raw;
    wire [c_NSIG-1:0]       w_filt;
    wire [CH_NUM*CNT_W-1:0] w_cw_all;
    wire [CH_NUM*CNT_W-1:0] w_ccw_all;
    wire [CH_NUM*CNT_W-1:0] w_pos_all;
    wire [CH_NUM-1:0]       w_dir_all;
    wire [CH_NUM-1:0]       w_evt_all;
    wire [CH_NUM-1:0]       w_err_all;
    wire [CH_NUM-1:0]       w_key_all;

    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;
    logic [c_NSIG-1:0]  r_sync1;
    logic [c_NSIG-1:0]  r_sync2;
    logic               r_clr_s1;
    logic               r_clr_s2;
    logic               r_clr_d;
    logic               w_clr;
    logic               r_mode;

    assign w_tick = (r_div == c_DIV_LAST);
    assign w_clr  = r_clr_s2 & ~r_clr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div    <= '0;
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
            r_clr_d  <= 1'b0;
            r_mode   <= 1'b0;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_clr_s1 <= bus.clr_i;
            r_clr_s2 <= r_clr_s1;
            r_clr_d  <= r_clr_s2;
            r_mode   <= bus.mode_i;
        end
    end

    // Flatten every debounced pin into one vector: A, B[, D] per channel
    for (genvar g = 0; g < CH_NUM; g++) begin : g_raw
        assign w_raw[g*c_SIG_PER_CH]     = bus.a_i[g];
        assign w_raw[g*c_SIG_PER_CH + 1] = bus.b_i[g];
`ifdef ENC_KEY_EN
        assign w_raw[g*c_SIG_PER_CH + 2] = bus.d_i[g];
`endif
    end

    for (genvar g = 0; g < c_NSIG; g++) begin : g_deb
        logic [3:0] r_cnt;
        logic       r_filt;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt  <= '0;
                r_filt <= 1'b1;
            end else if (w_tick) begin
                if (r_sync2[g] == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_cnt  <= '0;
                    r_filt <= r_sync2[g];
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
        assign w_filt[g] = r_filt;
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [1:0]       w_cur;
        logic [1:0]       r_prev;
        logic             w_step_cw;
        logic             w_step_ccw;
        logic             w_bad;
        logic             w_pos_en;
        logic [CNT_W-1:0] r_cw;
        logic [CNT_W-1:0] r_ccw;
        logic [CNT_W-1:0] r_pos;
        logic             r_dir;
        logic             r_evt;
        logic             r_err;

        assign w_cur = {w_filt[g*c_SIG_PER_CH], w_filt[g*c_SIG_PER_CH + 1]};
`ifdef ENC_KEY_EN
        assign w_key_all[g] = ~w_filt[g*c_SIG_PER_CH + 2];
        assign w_pos_en     = ~w_key_all[g];
`else
        assign w_key_all[g] = 1'b0;
        assign w_pos_en     = 1'b1;
`endif

        // CW walks 11-01-00-10, CCW the reverse; x1 counts only arrival at 11
        always_comb begin
            w_step_cw  = 1'b0;
            w_step_ccw = 1'b0;
            w_bad      = ((r_prev ^ w_cur) == 2'b11);
            if (r_mode) begin
                case ({r_prev, w_cur})
                    4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: w_step_cw  = 1'b1;
                    4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: w_step_ccw = 1'b1;
                    default: ;
                endcase
            end else begin
                w_step_cw  = ({r_prev, w_cur} == 4'b10_11);
                w_step_ccw = ({r_prev, w_cur} == 4'b01_11);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_prev <= 2'b11;
                r_cw   <= '0;
                r_ccw  <= '0;
                r_pos  <= '0;
                r_dir  <= 1'b0;
                r_evt  <= 1'b0;
                r_err  <= 1'b0;
            end else begin
                r_prev <= w_cur;
                r_evt  <= (w_step_cw | w_step_ccw) & ~w_clr;
                if (w_clr) begin
                    r_cw  <= '0;
                    r_ccw <= '0;
                    r_pos <= '0;
                    r_err <= 1'b0;
                end else begin
                    if (w_bad) begin
                        r_err <= 1'b1;
                    end
                    if (w_step_cw) begin
                        r_cw  <= r_cw + 1'b1;
                        r_dir <= 1'b1;
                        if (w_pos_en && (r_pos != c_POS_MAX)) begin
                            r_pos <= r_pos + 1'b1;
                        end
                    end else if (w_step_ccw) begin
                        r_ccw <= r_ccw + 1'b1;
                        r_dir <= 1'b0;
                        if (w_pos_en && (r_pos != c_POS_MIN)) begin
                            r_pos <= r_pos - 1'b1;
                        end
                    end
                end
            end
        end

        assign w_cw_all[g*CNT_W +: CNT_W]  = r_cw;
        assign w_ccw_all[g*CNT_W +: CNT_W] = r_ccw;
        assign w_pos_all[g*CNT_W +: CNT_W] = r_pos;
        assign w_dir_all[g]                = r_dir;
        assign w_evt_all[g]                = r_evt;
        assign w_err_all[g]                = r_err;
    end

    assign bus.cw_cnt_o  = w_cw_all;
    assign bus.ccw_cnt_o = w_ccw_all;
    assign bus.pos_o     = w_pos_all;
    assign bus.dir_o     = w_dir_all;
    assign bus.evt_o     = w_evt_all;
    assign bus.err_o     = w_err_all;
    assign bus.key_o     = w_key_all;

endmodule
`default_nettype wire

// File: tb/tb_quad_enc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_enc_ctrl
//  Purpose  : Directed self-checking bench for quad_enc_ctrl (both builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_quad_enc_ctrl;
    localparam int c_CH  = 2;
    localparam int c_W   = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;
    int   ph [c_CH];
    int   evt_hi0 = 0, evt_hi1 = 0, evt_rise0 = 0;
    logic evt_prev0 = 1'b0;

    quad_enc_ctrl_if #(.CH_NUM(c_CH), .CNT_W(c_W)) bus ();

    quad_enc_ctrl #(
        .CH_NUM (c_CH),
        .CNT_W  (c_W),
        .CLK_DIV(4),
        .DEB_LEN(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.evt_o[0]) evt_hi0++;
            if (bus.evt_o[1]) evt_hi1++;
            if (bus.evt_o[0] && !evt_prev0) evt_rise0++;
            evt_prev0 = bus.evt_o[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cw(input int ch);
        return bus.cw_cnt_o[ch*c_W +: c_W];
    endfunction
    function automatic logic [7:0] ccw(input int ch);
        return bus.ccw_cnt_o[ch*c_W +: c_W];
    endfunction
    function automatic logic [7:0] pos(input int ch);
        return bus.pos_o[ch*c_W +: c_W];
    endfunction

    // Phase index along the CW sequence 11,01,00,10
    task automatic move(input int ch, input bit dir_cw);
        logic [1:0] ab;
        ph[ch] = dir_cw ? (ph[ch] + 1) % 4 : (ph[ch] + 3) % 4;
        case (ph[ch])
            0:       ab = 2'b11;
            1:       ab = 2'b01;
            2:       ab = 2'b00;
            default: ab = 2'b10;
        endcase
        bus.a_i[ch] = ab[1];
        bus.b_i[ch] = ab[0];
    endtask

    task automatic step(input int ch, input bit dir_cw);
        @(negedge clk_i);
        move(ch, dir_cw);
        repeat (20) @(negedge clk_i);
    endtask

    task automatic clr_pulse();
        @(negedge clk_i);
        bus.clr_i = 1'b1;
        repeat (6) @(negedge clk_i);
        bus.clr_i = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic wait_evt(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
            if (bus.evt_o[0]) found = 1'b1;
        end
        chk("evt_seen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        int lat, dummy, e0;
        ph[0] = 0;
        ph[1] = 0;
        bus.a_i = '1; bus.b_i = '1; bus.d_i = '1;
        bus.mode_i = 1'b1; bus.clr_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        chk("rst_cw0", cw(0), 0);
        chk("rst_ccw0", ccw(0), 0);
        chk("rst_pos0", pos(0), 0);
        chk("rst_dir", bus.dir_o, 0);
        chk("rst_evt", bus.evt_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_key", bus.key_o, 0);

        // x4, one full CW cycle on ch0
        repeat (4) step(0, 1'b1);
        chk("x4_cw0", cw(0), 4);
        chk("x4_pos0", pos(0), 4);
        chk("x4_dir0", bus.dir_o[0], 1);
        chk("x4_evt_cycles", evt_hi0, 4);
        chk("x4_evt_pulses", evt_rise0, 4);
        chk("x4_ccw0", ccw(0), 0);
        chk("x4_cw1", cw(1), 0);
        chk("x4_pos1", pos(1), 0);
        chk("x4_evt1", evt_hi1, 0);

        clr_pulse();
        chk("clr_cw0", cw(0), 0);
        chk("clr_pos0", pos(0), 0);
        chk("clr_keeps_dir", bus.dir_o[0], 1);

        // x1, two full CCW cycles
        bus.mode_i = 1'b0;
        repeat (8) step(0, 1'b0);
        chk("x1_ccw0", ccw(0), 2);
        chk("x1_pos0", pos(0), 8'hFE);
        chk("x1_dir0", bus.dir_o[0], 0);
        chk("x1_cw0", cw(0), 0);
        chk("x1_evt_pulses", evt_rise0, 6);

        // one-tick glitch on A must be filtered out
        e0 = evt_hi0;
        @(negedge clk_i);
        bus.a_i[0] = 1'b0;
        repeat (4) @(negedge clk_i);
        bus.a_i[0] = 1'b1;
        repeat (30) @(negedge clk_i);
        chk("glitch_evt", evt_hi0, e0);
        chk("glitch_ccw0", ccw(0), 2);
        chk("glitch_pos0", pos(0), 8'hFE);
        chk("glitch_err0", bus.err_o[0], 0);

        // both phases flip together
        @(negedge clk_i);
        bus.a_i[0] = 1'b0;
        bus.b_i[0] = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("err_flag0", bus.err_o[0], 1);
        chk("err_flag1", bus.err_o[1], 0);
        chk("err_ccw0", ccw(0), 2);
        chk("err_pos0", pos(0), 8'hFE);
        chk("err_cw0", cw(0), 0);
        bus.a_i[0] = 1'b1;
        bus.b_i[0] = 1'b1;
        repeat (20) @(negedge clk_i);
        clr_pulse();
        chk("errclr_flag0", bus.err_o[0], 0);
        chk("errclr_ccw0", ccw(0), 0);
        chk("errclr_pos0", pos(0), 0);

        // saturation at +127
        bus.mode_i = 1'b1;
        repeat (130) step(0, 1'b1);
        chk("sat_cw0", cw(0), 8'h82);
        chk("sat_pos0", pos(0), 8'h7F);
        chk("sat_dir0", bus.dir_o[0], 1);

        // align a clear with a step on the same clock
        @(negedge clk_i);
        move(0, 1'b1);
        wait_evt(dummy);
        repeat (12) @(posedge clk_i);
        @(negedge clk_i);
        move(0, 1'b1);
        wait_evt(lat);
        if (lat < 4) lat = 4;
        repeat (12) @(posedge clk_i);
        @(negedge clk_i);
        e0 = evt_hi0;
        move(0, 1'b1);
        repeat (lat - 3) @(posedge clk_i);
        @(negedge clk_i);
        bus.clr_i = 1'b1;
        repeat (20) @(negedge clk_i);
        chk("clrstep_evt", evt_hi0, e0);
        chk("clrstep_cw0", cw(0), 0);
        chk("clrstep_pos0", pos(0), 0);

        // clr still high: no further clearing
        step(0, 1'b1);
        chk("clrheld_cw0", cw(0), 1);
        chk("clrheld_pos0", pos(0), 1);
        bus.clr_i = 1'b0;
        repeat (6) @(negedge clk_i);

        // push key held during CW steps
        clr_pulse();
        bus.d_i[0] = 1'b0;
        repeat (20) @(negedge clk_i);
        repeat (4) step(0, 1'b1);
        chk("key_cw0", cw(0), 4);
`ifdef ENC_KEY_EN
        chk("key_on", bus.key_o[0], 1);
        chk("key_pos0", pos(0), 0);
`else
        chk("key_on", bus.key_o[0], 0);
        chk("key_pos0", pos(0), 4);
`endif
        bus.d_i[0] = 1'b1;
        repeat (20) @(negedge clk_i);
        chk("key_off", bus.key_o[0], 0);

        // simultaneous CCW steps on both channels
        @(negedge clk_i);
        move(0, 1'b0);
        move(1, 1'b0);
        repeat (20) @(negedge clk_i);
        chk("sim_ccw0", ccw(0), 1);
        chk("sim_ccw1", ccw(1), 1);
        chk("sim_pos1", pos(1), 8'hFF);
        chk("sim_dir1", bus.dir_o[1], 0);
        chk("sim_cw1", cw(1), 0);
`ifdef ENC_KEY_EN
        chk("sim_pos0", pos(0), 8'hFF);
`else
        chk("sim_pos0", pos(0), 8'h03);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/quad_enc_ctrl.md
Name: quad_enc_ctrl

Overview:
- Multi-channel quadrature rotary-encoder controller. Parametrised successor of the single-EC11B detent counter.
- Per channel: synchronises and debounces A/B (and optional push key), then decodes Gray transitions in x1 (detent) or x4 mode.
- Keeps per-channel CW/CCW event counters, a saturating signed position, direction and error flags.
- Sits between front-panel encoder pins and the CPU register block. Everything runs on clk_i, using a clock-enable tick instead of a derived clock.

Parameters:
- CH_NUM, 2: number of encoder channels.
- CNT_W, 8: width of each counter (cw, ccw, pos).
- CLK_DIV, 25000: sample-tick period in clk_i cycles; must be >= 2.
- DEB_LEN, 3: consecutive equal samples required to accept a new input level; range 1..15.

Ports:
- clk_i  in  1  system clock (50 MHz).
- rst_i  in  1  asynchronous, active-high reset.
- a_i  in  CH_NUM  encoder phase A, idle high.
- b_i  in  CH_NUM  encoder phase B, idle high.
- d_i  in  CH_NUM  push key, active low. Used only with ENC_KEY_EN.
- mode_i  in  1  0 = x1 (one count per detent), 1 = x4 (count every edge).
- clr_i  in  1  asynchronous clear request; acts on its rising edge.
- cw_cnt_o  out  CH_NUM*CNT_W  CW step counts; channel n at [n*CNT_W +: CNT_W].
- ccw_cnt_o  out  CH_NUM*CNT_W  CCW step counts, same packing.
- pos_o  out  CH_NUM*CNT_W  signed position (two's complement), same packing.
- dir_o  out  CH_NUM  last counted direction: 1 = CW, 0 = CCW.
- evt_o  out  CH_NUM  one-clk_i pulse per counted step.
- err_o  out  CH_NUM  sticky illegal-transition flag.
- key_o  out  CH_NUM  debounced key state, 1 = pressed.

Behaviour:
- Reset (rst_i=1, async): all counters 0, pos 0, dir_o 0, evt_o 0, err_o 0, key_o 0. Sync and filtered A/B/D registers = 1. Tick divider = 0. Debounce counters = 0.
- Tick: divider counts 0..CLK_DIV-1 on every clk_i. tick=1 for exactly one cycle when divider = CLK_DIV-1, then the divider wraps to 0.
- Synchroniser: a_i, b_i, d_i, clr_i each pass a 2-FF synchroniser on every clk_i, independent of tick.
- Debounce, per signal, evaluated on tick cycles only:
  - synced != filtered: increment stable count. When the count reaches DEB_LEN, load filtered = synced and zero the count.
  - synced == filtered: zero the count.
  - A glitch shorter than DEB_LEN ticks never reaches filtered.
- Decode, per channel, every clk_i: compare prev = {A,B} filtered from the last cycle with cur = {A,B} filtered now.
  - CW sequence: 11->01->00->10->11.
  - CCW sequence: 11->10->00->01->11.
  - x4 mode: every legal single-bit change is a step in its direction.
  - x1 mode: only entry into 11 counts. 01->11 = CCW, 10->11 = CW. All other legal changes are ignored.
  - Both bits change in one cycle: set err_o, no count, prev still updates.
- Step action, one cycle after the filtered change:
  - CW: cw_cnt+1 (wraps modulo 2^CNT_W); pos+1, saturating at +(2^(CNT_W-1)-1); dir_o=1; evt_o=1 for one cycle.
  - CCW: ccw_cnt+1 (wraps); pos-1, saturating at -2^(CNT_W-1); dir_o=0; evt_o=1.
  - A saturated pos holds its value, but cw_cnt/ccw_cnt and evt_o still update.
- Clear: a rising edge of synced clr_i (0 then 1 on consecutive clk_i) zeroes cw/ccw/pos and err_o for all channels in the next cycle.
  - dir_o and key_o are unaffected.
  - Clear and step in the same cycle: clear wins, and evt_o is suppressed for that cycle.
  - clr_i held high clears only once.
- mode_i is sampled every clk_i; a change takes effect on the next transition.
- Channels are fully independent, and simultaneous steps on several channels are all counted.
- Latency from an input change to the counter update: 2 clk_i (sync) + DEB_LEN ticks (worst case +1 tick) + 1 clk_i.

Optional Feature:
- Macro ENC_KEY_EN.
- Defined: d_i is synchronised and debounced with the same DEB_LEN rule; key_o = ~filtered d. While key_o=1, steps on that channel update cw_cnt/ccw_cnt but not pos_o ("coarse-adjust lock").
- Undefined: d_i is ignored, key_o is tied to 0, no key logic is built, and pos_o always updates.

Test Plan:
- Bench parameters CLK_DIV=4, DEB_LEN=2, CH_NUM=2, CNT_W=8, mode_i=1. Ch0 driven 11->01->00->10->11 with each level held 20 clk_i -> cw_cnt0=4, pos0=+4, dir_o[0]=1, four 1-cycle evt_o[0] pulses; ch1 unchanged at 0.
- mode_i=0, ch0 driven through two full CCW cycles (11->10->00->01->11 twice) -> ccw_cnt0=2, pos0=-2 (0xFE), dir_o[0]=0.
- Pulse a_i[0] low for 4 clk_i (1 tick) -> no filtered change, no evt_o, all counters unchanged.
- Force filtered 11->00 by switching A and B together -> err_o[0]=1 with counters unchanged; then a clr_i rising edge -> err_o[0]=0 and all counters 0.
- 130 CW x4 steps on ch0 -> pos0 saturates at 0x7F, cw_cnt0=130 (0x82); issue clr_i on the same cycle as a step -> counters 0 and no evt_o.
- With ENC_KEY_EN: hold d_i[0]=0 and apply 4 CW steps -> key_o[0]=1, cw_cnt0=4, pos0=0. Without ENC_KEY_EN: key_o stays 0 and pos0=4.
